// File: rtl/guess_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : guess_ctrl
// Summary  : Control FSM for the guessing game: seeds the secret from the
//            start-button hold time, takes one guess per submit press and
//            drives the hint, win and lose indicators.
// Revision : 1.0 - initial release
// ============================================================================
module guess_ctrl #(
    parameter int HOLD_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_start,
    input  logic       i_submit,
    input  logic       i_over,
    input  logic       i_under,
    input  logic       i_equal,
    input  logic [3:0] i_remain,
    output logic       o_dp_reset,
    output logic       o_inc_actual,
    output logic       o_remain_en,
    output logic       o_ready,
    output logic       o_hint_over,
    output logic       o_hint_under,
    output logic       o_win,
    output logic       o_lose
);

    localparam int                 c_HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_SEED    = 3'd2,
        S_WAIT    = 3'd3,
        S_COMPARE = 3'd4,
        S_HINT    = 3'd5,
        S_WIN     = 3'd6,
        S_LOSE    = 3'd7
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_start_q;
    logic                r_submit_q;
    logic [c_HOLD_W-1:0] r_hold;
    logic                r_hint_over;
    logic                r_hint_under;
    logic                w_start_rise;
    logic                w_submit_rise;

    assign w_start_rise  = i_start  & ~r_start_q;
    assign w_submit_rise = i_submit & ~r_submit_q;

    // Edge registers reset high so a button held through reset is not an edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_start_q    <= 1'b1;
            r_submit_q   <= 1'b1;
            r_hold       <= '0;
            r_hint_over  <= 1'b0;
            r_hint_under <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_start_q  <= i_start;
            r_submit_q <= i_submit;

            if (r_state == S_COMPARE && w_next == S_HINT) begin
                r_hold <= c_HOLD_LOAD;
            end else if (r_state == S_HINT && r_hold != '0) begin
                r_hold <= r_hold - 1'b1;
            end

            if (r_state == S_CLEAR) begin
                r_hint_over  <= 1'b0;
                r_hint_under <= 1'b0;
            end else if (r_state == S_COMPARE) begin
                r_hint_over  <= ~i_equal & i_over;
                r_hint_under <= ~i_equal & i_under;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        o_dp_reset   = 1'b0;
        o_inc_actual = 1'b0;
        o_remain_en  = 1'b0;
        o_ready      = 1'b0;
        o_win        = 1'b0;
        o_lose       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_rise) w_next = S_CLEAR;
            end
            S_CLEAR: begin
                o_dp_reset = 1'b1;
                w_next     = S_SEED;
            end
            S_SEED: begin
                o_inc_actual = i_start;
                if (!i_start) w_next = S_WAIT;
            end
            S_WAIT: begin
                o_ready = 1'b1;
                if (w_submit_rise) w_next = S_COMPARE;
            end
            S_COMPARE: begin
                if (i_equal) begin
                    w_next = S_WIN;
                end else begin
                    o_remain_en = 1'b1;
                    // A zero count means the datapath was never cleared; end the game.
                    w_next      = (i_remain <= 4'd1) ? S_LOSE : S_HINT;
                end
            end
            S_HINT: begin
                if (r_hold == '0) w_next = S_WAIT;
            end
            S_WIN: begin
                o_win = 1'b1;
                if (w_start_rise) w_next = S_CLEAR;
            end
            S_LOSE: begin
                o_lose = 1'b1;
                if (w_start_rise) w_next = S_CLEAR;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign o_hint_over  = r_hint_over;
    assign o_hint_under = r_hint_under;

endmodule
`default_nettype wire

// File: tb/tb_guess_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_guess_ctrl
// Summary  : Randomized self-checking bench for guess_ctrl with a datapath
//            model and a game-level reference of the expected outcomes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_guess_ctrl;

    localparam int c_HOLD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_start;
    logic       i_submit;
    logic       i_over;
    logic       i_under;
    logic       i_equal;
    logic [3:0] i_remain;
    logic       o_dp_reset;
    logic       o_inc_actual;
    logic       o_remain_en;
    logic       o_ready;
    logic       o_hint_over;
    logic       o_hint_under;
    logic       o_win;
    logic       o_lose;

    logic [7:0] guess      = 8'd0;
    logic       force_zero = 1'b0;
    logic [7:0] dp_actual  = 8'd0;
    logic [3:0] dp_remain  = 4'd7;

    int n_dprst = 0;
    int n_inc   = 0;
    int n_rem   = 0;
    int n_checks = 0;
    int n_fail   = 0;

    // Game-level reference
    int  m_secret;
    int  m_left;
    bit  m_over;

    guess_ctrl #(.HOLD_CYCLES(c_HOLD)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .i_start     (i_start),
        .i_submit    (i_submit),
        .i_over      (i_over),
        .i_under     (i_under),
        .i_equal     (i_equal),
        .i_remain    (i_remain),
        .o_dp_reset  (o_dp_reset),
        .o_inc_actual(o_inc_actual),
        .o_remain_en (o_remain_en),
        .o_ready     (o_ready),
        .o_hint_over (o_hint_over),
        .o_hint_under(o_hint_under),
        .o_win       (o_win),
        .o_lose      (o_lose)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: secret register, remaining counter, live compare.
    always @(posedge clk) begin
        if (o_dp_reset) begin
            dp_actual <= 8'd0;
            dp_remain <= 4'd7;
        end else begin
            if (o_inc_actual) dp_actual <= dp_actual + 8'd1;
            if (o_remain_en)  dp_remain <= dp_remain - 4'd1;
        end
    end

    assign i_over   = guess > dp_actual;
    assign i_under  = guess < dp_actual;
    assign i_equal  = guess == dp_actual;
    assign i_remain = force_zero ? 4'd0 : dp_remain;

    always @(negedge clk) begin
        if (o_dp_reset)   n_dprst++;
        if (o_inc_actual) n_inc++;
        if (o_remain_en)  n_rem++;
    end

    function automatic logic [7:0] outs();
        return {o_dp_reset, o_inc_actual, o_remain_en, o_ready,
                o_hint_over, o_hint_under, o_win, o_lose};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_game(input int hold);
        int b_dprst;
        int b_inc;
        b_dprst = n_dprst;
        b_inc   = n_inc;
        i_start = 1'b1;
        step(hold);
        i_start = 1'b0;
        step(1);
        m_secret = (hold - 2) % 256;
        m_left   = 7;
        m_over   = 1'b0;
        check_eq("seed_dp_reset_pulses", n_dprst - b_dprst, 1);
        check_eq("seed_inc_pulses", n_inc - b_inc, hold - 2);
        check_eq("seed_actual", dp_actual, m_secret);
        check_eq("seed_remain", dp_remain, 7);
        check_eq("seed_ready", o_ready, 1);
        check_eq("seed_hints", {o_hint_over, o_hint_under}, 0);
    endtask

    task automatic do_guess(input logic [7:0] g, input bit filter);
        int  b_rem;
        int  n;
        int  sampled;
        bit  correct;
        bit  lost;
        logic [1:0] exp_hint;
        b_rem    = n_rem;
        i_submit = 1'b0;
        step(1);
        guess    = g;
        i_submit = 1'b1;
        step(1);
        correct  = (int'(g) == m_secret);
        sampled  = force_zero ? 0 : m_left;
        lost     = !correct && (sampled <= 1);
        exp_hint = correct ? 2'b00 : {int'(g) > m_secret, int'(g) < m_secret};
        if (!correct) m_left = m_left - 1;
        check_eq("cmp_remain_en", o_remain_en, !correct);
        check_eq("cmp_ready", o_ready, 0);
        if (!filter) i_submit = 1'b0;
        if (correct || lost) begin
            step(1);
            m_over = 1'b1;
            check_eq("end_win", o_win, correct);
            check_eq("end_lose", o_lose, lost);
            check_eq("end_hints", {o_hint_over, o_hint_under}, exp_hint);
            check_eq("end_remain", dp_remain, m_left[3:0]);
            check_eq("end_remain_pulses", n_rem - b_rem, !correct);
            i_submit = 1'b0;
        end else begin
            n = 0;
            while (!o_ready && n < 50) begin
                n++;
                if (filter) i_submit = (n == 2) ? 1'b0 : 1'b1;
                step(1);
            end
            check_eq("hint_ready_low_cycles", n, 1 + c_HOLD);
            check_eq("hint_flags", {o_hint_over, o_hint_under}, exp_hint);
            check_eq("hint_remain", dp_remain, m_left[3:0]);
            if (filter) begin
                step(3);
                check_eq("filter_still_ready", o_ready, 1);
                check_eq("filter_one_compare", n_rem - b_rem, 1);
            end
        end
    endtask

    function automatic logic [7:0] wrong_guess();
        return 8'((m_secret + 1 + int'($urandom_range(0, 254))) % 256);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b;
        reset    = 1'b0;
        i_start  = 1'b1;
        i_submit = 1'b0;
        step(2);
        reset = 1'b1;
        step(3);
        check_eq("reset_held_outs", outs(), 0);
        check_eq("reset_held_no_clear", n_dprst, 0);
        i_start = 1'b0;
        step(1);
        check_eq("reset_idle_outs", outs(), 0);

        // Directed game: too low, too high, then the win.
        start_game(12);
        do_guess(8'd3, 1'b0);
        do_guess(8'd20, 1'b1);
        do_guess(8'd10, 1'b0);

        // Start presses during an active game are ignored.
        start_game(12);
        b = n_dprst;
        i_start = 1'b1;
        step(2);
        i_start = 1'b0;
        step(1);
        check_eq("start_ignored_dprst", n_dprst - b, 0);
        check_eq("start_ignored_ready", o_ready, 1);
        check_eq("start_ignored_actual", dp_actual, 10);

        // Seven wrong guesses lose.
        b = n_rem;
        while (!m_over) do_guess(wrong_guess(), 1'b0);
        check_eq("lose_pulses", n_rem - b, 7);
        check_eq("lose_final_remain", dp_remain, 0);

        // Restart from LOSE, then reset mid-hint.
        start_game(8);
        i_submit = 1'b1;
        guess    = 8'((m_secret + 50) % 256);
        step(3);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        i_submit = 1'b0;
        check_eq("midgame_reset_outs", outs(), 0);
        b = n_dprst;
        i_submit = 1'b1;
        step(3);
        i_submit = 1'b0;
        check_eq("midgame_reset_no_clear", n_dprst - b, 0);
        check_eq("midgame_reset_idle", outs(), 0);
        check_eq("midgame_dp_kept", dp_remain, 6);

        // A zero remain count ends the game on the first wrong guess.
        start_game(5);
        force_zero = 1'b1;
        do_guess(wrong_guess(), 1'b0);
        force_zero = 1'b0;

        // Secret wraps modulo 256.
        start_game(259);
        do_guess(8'd1, 1'b0);

        for (int gi = 0; gi < 6; gi++) begin
            start_game(int'($urandom_range(3, 40)));
            while (!m_over) begin
                if ($urandom_range(0, 4) == 0) do_guess(8'(m_secret), 1'($urandom_range(0, 1)));
                else do_guess(wrong_guess(), 1'($urandom_range(0, 1)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
